// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter behind the lisp_core register bus.
// A small FIFO decouples register writes from the serial frame sequencer.
module uart_tx_port #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_TICK  = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     bit_cnt;
    logic [15:0]     bit_cnt_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic [7:0]      shift;
    logic [7:0]      shift_next;
    logic            tx_next;
    logic            pop;
    logic            bit_done;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      fifo_head;

    logic            overflow;
    logic            sel_tx_data;
    logic            sel_status;
    logic            push_req;
    logic            push_ok;
    logic            ovf_set;
    logic            ovf_clr;
    logic            busy;
    logic [15:0]     status;
    logic            unused_write_hi;

    // Register decode and FIFO bookkeeping
    assign sel_tx_data     = (register_index == 7'd0);
    assign sel_status      = (register_index == 7'd1);
    assign push_req        = !reset && register_write && sel_tx_data;
    assign fifo_empty      = (count == '0);
    assign fifo_full       = (count == DEPTH_CNT);
    assign fifo_head       = fifo_mem[rd_ptr];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok         = push_req && (!fifo_full || pop);
    assign ovf_set         = push_req && fifo_full && !pop;
    assign ovf_clr         = register_write && sel_status && register_write_value[3];
    assign busy            = (state != IDLE);
    assign status          = {12'h000, overflow, busy, fifo_full, fifo_empty};
    assign unused_write_hi = ^register_write_value[15:8];
    assign bit_done        = (bit_cnt == LAST_TICK);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= register_write_value[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow && !ovf_clr) || ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            register_read_value <= 16'h0000;
        end else if (register_read) begin
            register_read_value <= sel_status ? status : 16'h0000;
        end
    end

    // Frame sequencer state
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = uart_tx;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_head;
                    bit_cnt_next = '0;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    // Back-to-back frames: reload straight into START with no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 16'd1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: transmit FIFO entries; legal values are powers of two, 2..64.
REQ-003 clk  input  1: the only clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on rising clk.
REQ-005 register_index  input  7: peripheral register select from lisp_core.
REQ-006 register_read  input  1: read strobe, one cycle per access.
REQ-007 register_write  input  1: write strobe, one cycle per access.
REQ-008 register_write_value  input  16: write data.
REQ-009 register_read_value  output  16: read data, registered.
REQ-010 uart_tx  output  1: serial line, idle high, 8N1 format.

Function
REQ-011 The block SHALL be the downstream consumer of lisp_core register accesses; index 0 SHALL be TX_DATA and index 1 SHALL be STATUS.
REQ-012 A write to index 0 SHALL push register_write_value[7:0] into the FIFO; bits [15:8] SHALL be ignored.
REQ-013 A push while the FIFO is full SHALL be dropped and SHALL set the sticky overflow flag, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-014 A write to index 1 with bit 3 = 1 SHALL clear overflow; all other write bits SHALL be ignored.
REQ-015 If a clear and a new overflow occur in the same cycle, overflow SHALL end the cycle set.
REQ-016 The STATUS read SHALL return {12'b0, overflow, busy, full, empty}: empty = FIFO count 0; full = count FIFO_DEPTH; busy = FSM not IDLE.
REQ-017 register_read_value SHALL update on the edge where register_read is high, with the value valid in the following cycle; it SHALL hold its value otherwise.
REQ-018 Reads of index 0 or of any index above 1 SHALL return 0, and writes to indices above 1 SHALL have no effect.
REQ-019 Simultaneous register_read and register_write SHALL both take effect, and the read SHALL return pre-write state.
REQ-020 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-021 On an edge in IDLE with the FIFO non-empty, the block SHALL pop the head into the shift register, enter START and drive uart_tx low.
REQ-022 A byte written while IDLE with an empty FIFO SHALL produce the start bit on the line 2 cycles after the write edge.
REQ-023 Each state SHALL last CLOCKS_PER_BIT cycles per bit, timed by a bit counter, giving START (1 bit, line 0) -> DATA (8 bits, LSB first) -> STOP (1 bit, line 1).
REQ-024 A full frame SHALL be exactly 10*CLOCKS_PER_BIT cycles.
REQ-025 At the end of STOP, if the FIFO is non-empty the block SHALL pop and enter START directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-027 uart_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-028 While reset is high, the block SHALL hold FSM = IDLE, FIFO empty (pointers and count 0), overflow = 0, bit counter = 0, uart_tx = 1 and register_read_value = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with uart_tx high on the next edge; queued bytes SHALL be discarded.
REQ-030 Register accesses during reset SHALL be ignored.

Verification (CLOCKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Write 0x41 to index 0 at edge N -> uart_tx low over N+2..N+5, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; STATUS afterwards = 0x0001.
REQ-032 Six back-to-back writes 0x30..0x35 starting from IDLE -> the first byte pops; 0x30..0x34 are accepted and 0x35 is dropped; STATUS = 0x000E (overflow, busy, full); the line sends five contiguous 40-cycle frames.
REQ-033 After REQ-032, write 0x0008 to index 1 -> STATUS read = 0x0006 while queued bytes remain (overflow cleared, busy, full).
REQ-034 Push on the exact edge of the STOP->START pop while full -> the push is accepted and overflow stays 0.
REQ-035 Reset asserted during the DATA state of byte 0x55 with 2 bytes queued -> uart_tx = 1 next cycle; STATUS = 0x0001; no further frames.
REQ-036 Read index 5 and write index 5 with 0xFFFF -> read returns 0x0000 the next cycle; FIFO and flags are unchanged.
